uart_tx_arbiter: RTL and testbench

Shares the single UART transmit byte path of the Arty-A7 UART design between NUM_REQ independent byte-stream sources, such as the echo path, a status reporter and a debug dump. Round-robin arbitration happens at packet granularity. A grant is held until the owner's last byte has been transmitted, so packets never interleave. The block sits between the requesters and the UART transmitter's valid/ready byte interface, and drives a one-byte output register into that interface.

---
 rtl/uart_tx_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmit byte path between NUM_REQ byte-stream sources.
// Round-robin arbitration at packet granularity: once a requester is granted
// it owns the output until its last byte has been handed to the transmitter,
// so packets never interleave. An owner that stalls mid-packet for TIMEOUT
// cycles loses the grant and raises a sticky timeout_err.
//
// Ports:
//   CLK100MHZ   in   system clock
//   ck_rst      in   asynchronous reset, active-low
//   req_valid   in   [NUM_REQ]        per-requester byte valid
//   req_data    in   [NUM_REQ*DATA_W] requester i byte at [i*DATA_W +: DATA_W]
//   req_last    in   [NUM_REQ]        final byte of a packet (with req_valid)
//   req_ready   out  [NUM_REQ]        per-requester byte accept
//   tx_valid    out                   byte valid to the UART transmitter
//   tx_data     out  [DATA_W]         byte to the UART transmitter
//   tx_ready    in                    UART transmitter accepts a byte
//   grant_id    out  [clog2(NUM_REQ)] current owner, holds last value when idle
//   busy        out                   arbiter is not idle
//   timeout_err out                   sticky, set on a forced release
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                        CLK100MHZ,
  input  logic                        ck_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_valid,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [10:0] TO_LIMIT = 11'(TIMEOUT);

  logic [1:0]                      state_r, state_n_s;
  logic [GW-1:0]                   rr_ptr_r, rr_ptr_n_s;
  logic [GW-1:0]                   grant_r, grant_n_s, pick_s;
  logic                            tx_valid_r, tx_valid_n_s;
  logic [DATA_W-1:0]               tx_data_r, tx_data_n_s;
  logic                            busy_r;
  logic                            timeout_err_r, timeout_err_n_s;
  logic [9:0]                      cnt_r, cnt_n_s;
  logic [10:0]                     cnt_inc_s;
  logic [NUM_REQ-1:0][DATA_W-1:0]  req_bytes_s;
  logic [DATA_W-1:0]               own_data_s;
  logic                            own_ready_s, own_valid_s, own_last_s;
  logic                            accept_s, tx_hs_s, to_hit_s;

  // First requester with valid set, searching upward from ptr+1 (mod NUM_REQ).
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                            input logic [GW-1:0] ptr);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && v[idx]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign req_bytes_s = req_data;
  assign own_data_s  = req_bytes_s[grant_r];
  assign own_valid_s = req_valid[grant_r];
  assign own_last_s  = req_last[grant_r];
  // Ready depends on registers only, so there is no path from req_valid.
  assign own_ready_s = (state_r == ST_LOCK) && !tx_valid_r;
  assign accept_s    = own_ready_s && own_valid_s;
  assign tx_hs_s     = tx_valid_r && tx_ready;
  assign pick_s      = rr_pick(req_valid, rr_ptr_r);
  assign cnt_inc_s   = {1'b0, cnt_r} + 11'd1;
  assign to_hit_s    = (cnt_inc_s >= TO_LIMIT);

  // Per-requester ready: only the owner, and only while the output slot is empty.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if (own_ready_s) begin
      req_ready[grant_r] = 1'b1;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Next-state logic for arbitration, output byte slot and stall timeout.
  always_comb begin
    state_n_s       = state_r;
    rr_ptr_n_s      = rr_ptr_r;
    grant_n_s       = grant_r;
    tx_valid_n_s    = tx_valid_r;
    tx_data_n_s     = tx_data_r;
    timeout_err_n_s = timeout_err_r;
    cnt_n_s         = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_n_s = 10'd0;
        if (|req_valid) begin
          state_n_s = ST_LOCK;
          grant_n_s = pick_s;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (accept_s) begin
          tx_valid_n_s = 1'b1;
          tx_data_n_s  = own_data_s;
          cnt_n_s      = 10'd0;
          if (own_last_s) begin
            state_n_s = ST_DRAIN;
          end else begin
            state_n_s = ST_LOCK;
          end
        end else if (!tx_valid_r && to_hit_s) begin
          // Forced release; a byte still in the slot is sent first because
          // this branch needs tx_valid low.
          state_n_s       = ST_IDLE;
          timeout_err_n_s = 1'b1;
          rr_ptr_n_s      = grant_r;
          cnt_n_s         = 10'd0;
        end else begin
          state_n_s = ST_LOCK;
          if (tx_hs_s) begin
            tx_valid_n_s = 1'b0;
          end else begin
            tx_valid_n_s = tx_valid_r;
          end
          // Saturate so a long transmitter stall still releases once the
          // pending byte has gone.
          if (to_hit_s) begin
            cnt_n_s = TO_LIMIT[9:0];
          end else begin
            cnt_n_s = cnt_inc_s[9:0];
          end
        end
      end
      ST_DRAIN: begin
        if (tx_hs_s) begin
          tx_valid_n_s = 1'b0;
          rr_ptr_n_s   = grant_r;
          state_n_s    = ST_IDLE;
        end else begin
          state_n_s = ST_DRAIN;
        end
      end
      default: begin
        state_n_s    = ST_IDLE;
        tx_valid_n_s = 1'b0;
        cnt_n_s      = 10'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK100MHZ or negedge ck_rst) begin
    if (!ck_rst) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= GW'(NUM_REQ - 1);
      grant_r       <= {GW{1'b0}};
      tx_valid_r    <= 1'b0;
      tx_data_r     <= {DATA_W{1'b0}};
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      cnt_r         <= 10'd0;
    end else begin
      state_r       <= state_n_s;
      rr_ptr_r      <= rr_ptr_n_s;
      grant_r       <= grant_n_s;
      tx_valid_r    <= tx_valid_n_s;
      tx_data_r     <= tx_data_n_s;
      busy_r        <= (state_n_s != ST_IDLE);
      timeout_err_r <= timeout_err_n_s;
      cnt_r         <= cnt_n_s;
    end
  end

  assign tx_valid    = tx_valid_r;
  assign tx_data     = tx_data_r;
  assign grant_id    = grant_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           ck_rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [W-1:0]   tx_data;
  logic           tx_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-requester byte queues {last, data}, expected output {grant, last, data}.
  logic [8:0]  src_q [N][$];
  logic [10:0] exp_q [$];
  int          rr_m;
  logic [N-1:0] mid;
  int          gap_cnt [N];
  int          stall_cnt;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .CLK100MHZ  (clk),
    .ck_rst     (ck_rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Packet-level round robin over all queued packets.
  task automatic model_plan();
    int ptr [N];
    int win;
    int r;
    logic [8:0] e;
    for (int i = 0; i < N; i++) ptr[i] = 0;
    win = 0;
    while (win >= 0) begin
      win = -1;
      for (int k = 1; k <= N; k++) begin
        r = (rr_m + k) % N;
        if (win < 0 && ptr[r] < src_q[r].size()) win = r;
      end
      if (win >= 0) begin
        do begin
          e = src_q[win][ptr[win]];
          ptr[win]++;
          exp_q.push_back({2'(win), e});
        end while (!e[8]);
        rr_m = win;
      end
    end
  endtask

  task automatic drive_src(input bit gaps);
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic [N-1:0]   l;
    logic [8:0]     e;
    v = {N{1'b0}};
    d = {(N*W){1'b0}};
    l = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        e = src_q[i][0];
        d[i*W +: W] = e[7:0];
        l[i] = e[8];
        if (mid[i] && gaps && gap_cnt[i] < 3) v[i] = ($urandom_range(0, 99) < 70);
        else v[i] = 1'b1;
      end
      gap_cnt[i] = v[i] ? 0 : gap_cnt[i] + 1;
    end
    req_valid = v;
    req_data  = d;
    req_last  = l;
  endtask

  task automatic run_engine(input int budget, input bit rand_tx, input bit gaps, input int stall_after);
    int bytes_done;
    int stall_left;
    int after_last;
    int cyc;
    bit stall_done;
    logic [N-1:0] acc;
    logic [10:0] e;
    logic [8:0]  s;
    bytes_done = 0; stall_left = 0; after_last = 0; cyc = 0; stall_done = 1'b0;
    while ((exp_q.size() > 0 || after_last != 0) && cyc < budget) begin
      drive_src(gaps);
      if (stall_after >= 0 && !stall_done && tx_valid && bytes_done == stall_after) begin
        stall_left = 50;
        stall_done = 1'b1;
      end
      if (stall_left > 0) tx_ready = 1'b0;
      else if (rand_tx) begin
        tx_ready  = (stall_cnt >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        stall_cnt = tx_ready ? 0 : stall_cnt + 1;
      end else tx_ready = 1'b1;
      @(negedge clk);
      check_eq("ready_owner", 32'(req_ready & ~(4'b0001 << grant_id)), 32'd0);
      if (stall_left > 0) begin
        e = (exp_q.size() > 0) ? exp_q[0] : 11'd0;
        check_eq("stall_txv", 32'(tx_valid), 32'd1);
        check_eq("stall_data", 32'(tx_data), 32'(e[7:0]));
        check_eq("stall_ready", 32'(req_ready), 32'd0);
        stall_left--;
      end
      if (after_last == 1) begin
        check_eq("idle_after_last", 32'(busy), 32'd0);
        after_last = (exp_q.size() > 0) ? 2 : 0;
      end else if (after_last == 2) begin
        e = exp_q[0];
        check_eq("regrant_busy", 32'(busy), 32'd1);
        check_eq("regrant_id", 32'(grant_id), 32'(e[10:9]));
        after_last = 0;
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check_eq("tx_expected", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          check_eq("tx_data", 32'(tx_data), 32'(e[7:0]));
          check_eq("tx_grant", 32'(grant_id), 32'(e[10:9]));
          bytes_done++;
          if (e[8]) after_last = 1;
        end
      end
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_q[i].size() > 0) begin
          s = src_q[i].pop_front();
          mid[i] = !s[8];
        end
      end
      cyc++;
    end
    check_eq("engine_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    drive_src(gaps);
    tx_ready = 1'b1;
  endtask

  task automatic load_random();
    int np;
    int len;
    for (int i = 0; i < N; i++) begin
      np = $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++)
          src_q[i].push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a;
    ck_rst = 1'b0; req_valid = 4'd0; req_data = 32'd0; req_last = 4'd0; tx_ready = 1'b0;
    mid = 4'd0; stall_cnt = 0; rr_m = N - 1;
    for (int i = 0; i < N; i++) gap_cnt[i] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_txv", 32'(tx_valid), 32'd0);
    check_eq("rst_data", 32'(tx_data), 32'd0);
    check_eq("rst_grant", 32'(grant_id), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_terr", 32'(timeout_err), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    ck_rst = 1'b1;

    // Requester 2: 0x41 0x42 0x43.
    src_q[2].push_back(9'h041); src_q[2].push_back(9'h042); src_q[2].push_back(9'h143);
    model_plan();
    run_engine(200, 1'b0, 1'b0, -1);

    // Requesters 0 and 1 together, two 2-byte packets each: order 0,1,0,1.
    src_q[0].push_back(9'h0A0); src_q[0].push_back(9'h1A1);
    src_q[0].push_back(9'h0A2); src_q[0].push_back(9'h1A3);
    src_q[1].push_back(9'h0B0); src_q[1].push_back(9'h1B1);
    src_q[1].push_back(9'h0B2); src_q[1].push_back(9'h1B3);
    model_plan();
    run_engine(200, 1'b0, 1'b0, -1);

    // Back-to-back single-byte packets from requester 1.
    src_q[1].push_back(9'h17E); src_q[1].push_back(9'h181);
    model_plan();
    run_engine(200, 1'b0, 1'b0, -1);

    // 50-cycle transmitter stall on the second byte of a packet.
    src_q[0].push_back(9'h0C1); src_q[0].push_back(9'h0C2); src_q[0].push_back(9'h1C3);
    model_plan();
    run_engine(300, 1'b0, 1'b0, 1);

    // Timeout: requester 3 sends 0x10 without last and goes quiet; 0 waits.
    req_valid = 4'b1000; req_data = {8'h10, 24'h0}; req_last = 4'b0000; tx_ready = 1'b1;
    for (a = 0; a < 20; a++) begin
      @(negedge clk);
      if (req_valid[3] && req_ready[3]) break;
    end
    check_eq("to_accept", 32'(req_valid[3] & req_ready[3]), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'b0001; req_data = {24'h0, 8'h55}; req_last = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          check_eq("to_txv", 32'(tx_valid), 32'd1);
          check_eq("to_data", 32'(tx_data), 32'h10);
        end
        15: begin
          check_eq("to_busy_early", 32'(busy), 32'd1);
          check_eq("to_terr_early", 32'(timeout_err), 32'd0);
        end
        16: check_eq("to_busy_last", 32'(busy), 32'd1);
        17: begin
          check_eq("to_released", 32'(busy), 32'd0);
          check_eq("to_terr", 32'(timeout_err), 32'd1);
        end
        18: begin
          check_eq("to_next_busy", 32'(busy), 32'd1);
          check_eq("to_next_grant", 32'(grant_id), 32'd0);
          check_eq("to_next_ready", 32'(req_ready), 32'd1);
        end
        19: check_eq("to_next_data", 32'(tx_data), 32'h55);
        20: check_eq("to_next_done", 32'(busy), 32'd0);
        default: ;
      endcase
      @(posedge clk); #1;
      if (k == 18) begin
        req_valid = 4'd0;
        req_last  = 4'd0;
      end
    end
    rr_m = 0;

    // Randomized traffic against the packet-level model.
    for (int r = 0; r < 8; r++) begin
      load_random();
      model_plan();
      run_engine(3000, 1'b1, 1'b1, -1);
    end

    // Reset pulsed mid-packet with a byte held in the output slot.
    req_valid = 4'b1010; req_data = 32'h3300_1100; req_last = 4'b0000; tx_ready = 1'b0;
    for (a = 0; a < 20; a++) begin
      @(negedge clk);
      if (tx_valid) break;
    end
    check_eq("mr_setup_txv", 32'(tx_valid), 32'd1);
    #2 ck_rst = 1'b0;
    #1;
    check_eq("mr_txv", 32'(tx_valid), 32'd0);
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_terr", 32'(timeout_err), 32'd0);
    check_eq("mr_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    ck_rst = 1'b1;
    @(negedge clk);
    check_eq("mr_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("mr_busy_grant", 32'(busy), 32'd1);
    check_eq("mr_first_grant", 32'(grant_id), 32'd1);
    @(posedge clk); #1;
    req_valid = 4'd0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
